// File: rtl/uart_rx_buffered_pkg.sv
// Shared types and helpers for the buffered UART receiver.
package uart_rx_buffered_pkg;

    // Parity modes; the numeric value is what the PARITY parameter carries.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    // Deframing FSM states. ST_BREAK holds the receiver off the line after a
    // break character until rx returns high, so one break gives one entry.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4,
        ST_BREAK = 3'd5
    } rx_state_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Consumer-side port of the receive FIFO.
//
// Handshake: the head entry (m_data/m_perr/m_ferr) is presented while m_valid
// is high and is held unchanged until a cycle with m_valid & m_ready, on whose
// rising clock edge the entry is consumed. m_ready while m_valid is low is
// ignored. m_valid never depends combinationally on m_ready.
interface uart_rx_buffered_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] m_data;
    logic                 m_perr;
    logic                 m_ferr;
    logic                 m_valid;
    logic                 m_ready;

    modport master (output m_data, m_perr, m_ferr, m_valid, input m_ready);
    modport slave  (input m_data, m_perr, m_ferr, m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_buffered_fifo.sv
// Synchronous FIFO for received characters. Counters carry one extra wrap bit
// so that full and empty are distinguished by level = wr_cnt - rd_cnt.
module uart_rx_buffered_fifo
    import uart_rx_buffered_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [clog2(DEPTH):0]    level_o
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [AW:0]      wr_cnt_q;
    logic [AW:0]      rd_cnt_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign level_o = wr_cnt_q - rd_cnt_q;
    assign empty_o = (level_o == '0);
    assign full_o  = (level_o == FULL_LEVEL);

    // A pop frees a slot in the same cycle, so a push while full still lands
    // when the consumer is popping.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Head is forced to zero when empty so outputs read 0 out of reset.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_cnt_q[AW-1:0]];

    // Read/write counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (do_push) wr_cnt_q <= wr_cnt_q + 1'b1;
            if (do_pop)  rd_cnt_q <= rd_cnt_q + 1'b1;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_cnt_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver: rx synchroniser, baud/bit counters, deframing FSM, receive
// FIFO and sticky overrun flag. Each character is queued as {ferr,perr,data}.
module uart_rx_buffered
    import uart_rx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       rx,
    uart_rx_buffered_if.master         m,
    output logic [clog2(FIFO_DEPTH):0] level,
    output logic                       overrun,
    input  logic                       overrun_clr,
    output logic                       busy,
    output rx_state_e                  dbg_state
);
    localparam int CNT_W   = clog2(CLKS_PER_BIT);
    localparam int BIT_W   = clog2(DATA_BITS + 1);
    localparam int HALF_M1 = CLKS_PER_BIT / 2 - 1;
    localparam int CPB_M1  = CLKS_PER_BIT - 1;
    localparam int DB_M1   = DATA_BITS - 1;
    localparam int SB_M1   = STOP_BITS - 1;

    localparam logic [CNT_W-1:0] CNT_HALF = HALF_M1[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_FULL = CPB_M1[CNT_W-1:0];
    localparam logic [BIT_W-1:0] LAST_DB  = DB_M1[BIT_W-1:0];
    localparam logic [BIT_W-1:0] LAST_SB  = SB_M1[BIT_W-1:0];
    localparam logic HAS_PARITY = (PARITY != int'(PAR_NONE));
    localparam logic ODD_PARITY = (PARITY == int'(PAR_ODD));

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic                 rx_fall;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 baud_tick;
    logic                 push;
    logic [DATA_BITS+1:0] push_word;
    logic [DATA_BITS+1:0] head_word;
    logic                 fifo_full, fifo_empty;
    logic                 pop_eff;
    logic                 overrun_q;

    // Two-flop synchroniser plus a history flop for edge detection; all idle high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall   = rx_prev_q & ~rx_sync_q;
    assign baud_tick = (cnt_q == CNT_FULL);

    // Deframer state, baud counter, bit counter, shift register and error bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: start bit is checked at half a bit, everything else at bit centre.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rx_fall) begin
                    state_d = ST_START;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    cnt_d   = '0;
                    shreg_d = {rx_sync_q, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_DB) begin
                        bit_d   = '0;
                        state_d = HAS_PARITY ? ST_PAR : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (baud_tick) begin
                    cnt_d   = '0;
                    perr_d  = ((^shreg_q) ^ rx_sync_q) != ODD_PARITY;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    cnt_d  = '0;
                    ferr_d = ferr_q | ~rx_sync_q;
                    if (bit_q == LAST_SB) begin
                        push    = 1'b1;
                        state_d = (ferr_d && (shreg_q == '0)) ? ST_BREAK : ST_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_sync_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        push_word = {ferr_d, perr_q, shreg_q};
    end

    assign pop_eff = m.m_ready & ~fifo_empty;

    uart_rx_buffered_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i (push_word),
        .pop_i       (m.m_ready),
        .rd_data_o   (head_word),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level)
    );

    // Sticky overrun: set on a dropped character, which beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else if (push && fifo_full && !pop_eff) begin
            overrun_q <= 1'b1;
        end else if (overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign m.m_data  = head_word[DATA_BITS-1:0];
    assign m.m_perr  = head_word[DATA_BITS];
    assign m.m_ferr  = head_word[DATA_BITS+1];
    assign m.m_valid = ~fifo_empty;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: three instances (8N1/depth 8, 8E1/depth 4,
// 7O2/depth 8) driven with serial frames and checked against a queue model.
module tb_uart_rx_buffered;
    import uart_rx_buffered_pkg::*;

    localparam int CPB = 4;
    localparam int DB_A = 8, PAR_A = 0, SB_A = 1, D_A = 8;
    localparam int DB_B = 8, PAR_B = 2, SB_B = 1, D_B = 4;
    localparam int DB_C = 7, PAR_C = 1, SB_C = 2, D_C = 8;

    int cfg_db[3]    = '{DB_A, DB_B, DB_C};
    int cfg_par[3]   = '{PAR_A, PAR_B, PAR_C};
    int cfg_sb[3]    = '{SB_A, SB_B, SB_C};
    int cfg_depth[3] = '{D_A, D_B, D_C};

    logic      clk = 1'b0;
    logic      reset_n;
    logic      rx_l[3];
    logic      clr_l[3];
    logic      ovr_l[3];
    logic      busy_l[3];
    logic [3:0] lvl_a;
    logic [2:0] lvl_b;
    logic [3:0] lvl_c;
    rx_state_e st_a, st_b, st_c;

    uart_rx_buffered_if #(.DATA_BITS(DB_A)) if_a();
    uart_rx_buffered_if #(.DATA_BITS(DB_B)) if_b();
    uart_rx_buffered_if #(.DATA_BITS(DB_C)) if_c();

    uart_rx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB_A), .PARITY(PAR_A),
                       .STOP_BITS(SB_A), .FIFO_DEPTH(D_A)) dut_a (
        .clk(clk), .reset_n(reset_n), .rx(rx_l[0]), .m(if_a), .level(lvl_a),
        .overrun(ovr_l[0]), .overrun_clr(clr_l[0]), .busy(busy_l[0]), .dbg_state(st_a));
    uart_rx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB_B), .PARITY(PAR_B),
                       .STOP_BITS(SB_B), .FIFO_DEPTH(D_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .rx(rx_l[1]), .m(if_b), .level(lvl_b),
        .overrun(ovr_l[1]), .overrun_clr(clr_l[1]), .busy(busy_l[1]), .dbg_state(st_b));
    uart_rx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB_C), .PARITY(PAR_C),
                       .STOP_BITS(SB_C), .FIFO_DEPTH(D_C)) dut_c (
        .clk(clk), .reset_n(reset_n), .rx(rx_l[2]), .m(if_c), .level(lvl_c),
        .overrun(ovr_l[2]), .overrun_clr(clr_l[2]), .busy(busy_l[2]), .dbg_state(st_c));

    // Clock
    always #5 clk = ~clk;

    // Scoreboard: expected {ferr, perr, data[8:0]} per instance, plus overrun.
    logic [10:0] exp_q_a[$];
    logic [10:0] exp_q_b[$];
    logic [10:0] exp_q_c[$];
    bit          exp_ovr[3];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // DUT observation helpers
    function automatic logic [10:0] head(input int ch);
        case (ch)
            0:       return {if_a.m_ferr, if_a.m_perr, 1'b0, if_a.m_data};
            1:       return {if_b.m_ferr, if_b.m_perr, 1'b0, if_b.m_data};
            default: return {if_c.m_ferr, if_c.m_perr, 2'b00, if_c.m_data};
        endcase
    endfunction

    function automatic logic valid(input int ch);
        case (ch)
            0:       return if_a.m_valid;
            1:       return if_b.m_valid;
            default: return if_c.m_valid;
        endcase
    endfunction

    function automatic int lvl(input int ch);
        case (ch)
            0:       return int'(lvl_a);
            1:       return int'(lvl_b);
            default: return int'(lvl_c);
        endcase
    endfunction

    task automatic set_ready(input int ch, input logic v);
        case (ch)
            0:       if_a.m_ready = v;
            1:       if_b.m_ready = v;
            default: if_c.m_ready = v;
        endcase
    endtask

    // Model queue helpers
    function automatic int q_size(input int ch);
        case (ch)
            0:       return exp_q_a.size();
            1:       return exp_q_b.size();
            default: return exp_q_c.size();
        endcase
    endfunction

    task automatic q_push(input int ch, input logic [10:0] w);
        case (ch)
            0:       exp_q_a.push_back(w);
            1:       exp_q_b.push_back(w);
            default: exp_q_c.push_back(w);
        endcase
    endtask

    task automatic q_pop(input int ch, output logic [10:0] w);
        case (ch)
            0:       w = exp_q_a.pop_front();
            1:       w = exp_q_b.pop_front();
            default: w = exp_q_c.pop_front();
        endcase
    endtask

    // Expected entry from the framing rules: parity judged on total count of ones.
    function automatic logic [10:0] model_entry(input int ch, input logic [8:0] d,
                                                input logic pbit, input logic [1:0] stops);
        int   ones;
        logic perr, ferr;
        ones = $countones(d) + int'(pbit);
        perr = (cfg_par[ch] != 0) && (((ones % 2) == 1) != (cfg_par[ch] == 1));
        ferr = (stops[0] == 1'b0) || ((cfg_sb[ch] == 2) && (stops[1] == 1'b0));
        return {ferr, perr, d};
    endfunction

    task automatic model_store(input int ch, input logic [10:0] w);
        if (q_size(ch) < cfg_depth[ch]) q_push(ch, w);
        else exp_ovr[ch] = 1'b1;
    endtask

    // Driver tasks
    task automatic drive_bits(input int ch, input logic v, input int nbits);
        rx_l[ch] = v;
        repeat (nbits * CPB) @(negedge clk);
    endtask

    task automatic send_char(input int ch, input logic [8:0] data, input bit bad_par,
                             input int bad_stop, input int gap);
        logic [8:0] d;
        logic       pbit;
        logic [1:0] stops;
        d     = data & 9'((1 << cfg_db[ch]) - 1);
        pbit  = (cfg_par[ch] == 1) ? ~(^d) : (^d);
        if (bad_par) pbit = ~pbit;
        stops = 2'b11;
        if (bad_stop >= 0) stops[bad_stop] = 1'b0;
        drive_bits(ch, 1'b0, 1);
        for (int i = 0; i < cfg_db[ch]; i++) drive_bits(ch, d[i], 1);
        if (cfg_par[ch] != 0) drive_bits(ch, pbit, 1);
        for (int i = 0; i < cfg_sb[ch]; i++) drive_bits(ch, stops[i], 1);
        model_store(ch, model_entry(ch, d, pbit, stops));
        drive_bits(ch, 1'b1, gap);
    endtask

    task automatic check_state(input int ch, input string tag);
        check({tag, "_level"}, 32'(lvl(ch)), 32'(q_size(ch)));
        check({tag, "_valid"}, 32'(valid(ch)), 32'(q_size(ch) != 0));
        check({tag, "_overrun"}, 32'(ovr_l[ch]), 32'(exp_ovr[ch]));
    endtask

    // Pop everything the model expects, checking head value and its stability.
    task automatic drain(input int ch, input string tag);
        int k;
        k = 0;
        while (q_size(ch) > 0) begin
            logic [10:0] e;
            int          waited;
            waited = 0;
            while (!valid(ch) && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            q_pop(ch, e);
            check($sformatf("%s_pop%0d", tag, k), 32'(head(ch)), 32'(e));
            repeat ($urandom_range(1, 3)) @(negedge clk);
            check($sformatf("%s_hold%0d", tag, k), 32'(head(ch)), 32'(e));
            set_ready(ch, 1'b1);
            @(negedge clk);
            set_ready(ch, 1'b0);
            k++;
        end
        check({tag, "_empty_valid"}, 32'(valid(ch)), 32'(0));
        check({tag, "_empty_level"}, 32'(lvl(ch)), 32'(0));
    endtask

    task automatic pulse_clr(input int ch);
        clr_l[ch] = 1'b1;
        @(negedge clk);
        clr_l[ch] = 1'b0;
        exp_ovr[ch] = 1'b0;
    endtask

    // Watchdog
    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete within cycle budget");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_l[i]  = 1'b1;
            clr_l[i] = 1'b0;
            set_ready(i, 1'b0);
        end
        repeat (3) @(negedge clk);

        // Reset state on every instance
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst%0d_level", i), 32'(lvl(i)), 32'(0));
            check($sformatf("rst%0d_valid", i), 32'(valid(i)), 32'(0));
            check($sformatf("rst%0d_data", i), 32'(head(i)), 32'(0));
            check($sformatf("rst%0d_overrun", i), 32'(ovr_l[i]), 32'(0));
            check($sformatf("rst%0d_busy", i), 32'(busy_l[i]), 32'(0));
        end
        check("rst_state_a", 32'(st_a), 32'(ST_IDLE));
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1: two characters queued, then popped in order
        send_char(0, 9'h55, 1'b0, -1, 2);
        send_char(0, 9'hA3, 1'b0, -1, 2);
        check("t1_level_two", 32'(lvl(0)), 32'(2));
        check_state(0, "t1");
        check("t1_head_55", 32'(head(0)), 32'(11'h055));
        drain(0, "t1");

        // Even parity: good parity bit, then a flipped one
        send_char(1, 9'h07, 1'b0, -1, 2);
        send_char(1, 9'h07, 1'b1, -1, 2);
        check_state(1, "t2");
        check("t2_parity_ok", 32'(head(1)), 32'(11'h007));
        drain(1, "t2");

        // Framing error on 0x3C, then a break held for two character times
        send_char(0, 9'h3C, 1'b0, 0, 2);
        rx_l[0] = 1'b0;
        repeat (2 * 10 * CPB) @(negedge clk);
        check("t3_break_busy", 32'(busy_l[0]), 32'(1));
        model_store(0, 11'h400);
        drive_bits(0, 1'b1, 3);
        check("t3_break_idle", 32'(busy_l[0]), 32'(0));
        check("t3_level_two", 32'(lvl(0)), 32'(2));
        check_state(0, "t3");
        drain(0, "t3");

        // One-clock glitch in idle: no character, receiver back to idle
        rx_l[0] = 1'b0;
        @(negedge clk);
        rx_l[0] = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check("t4_glitch_busy", 32'(busy_l[0]), 32'(0));
        check("t4_glitch_level", 32'(lvl(0)), 32'(0));
        check("t4_glitch_state", 32'(st_a), 32'(ST_IDLE));

        // Reset in the middle of DATA
        send_char(0, 9'h11, 1'b0, -1, 2);
        check_state(0, "t5_pre");
        drive_bits(0, 1'b0, 1);
        drive_bits(0, 1'b0, 1);
        drive_bits(0, 1'b1, 1);
        drive_bits(0, 1'b1, 1);
        check("t5_busy_mid", 32'(busy_l[0]), 32'(1));
        reset_n = 1'b0;
        #1;
        check("t5_rst_level", 32'(lvl(0)), 32'(0));
        check("t5_rst_valid", 32'(valid(0)), 32'(0));
        check("t5_rst_busy", 32'(busy_l[0]), 32'(0));
        exp_q_a.delete();
        exp_q_b.delete();
        exp_q_c.delete();
        for (int i = 0; i < 3; i++) exp_ovr[i] = 1'b0;
        rx_l[0] = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5 * CPB) @(negedge clk);
        check("t5_after_busy", 32'(busy_l[0]), 32'(0));
        check("t5_after_valid", 32'(valid(0)), 32'(0));
        send_char(0, 9'h9E, 1'b0, -1, 2);
        check("t5_head_9e", 32'(head(0)), 32'(11'h09E));
        drain(0, "t5");

        // Depth-4 overrun: six characters, first four kept
        for (int i = 1; i <= 6; i++) send_char(1, 9'(i), 1'b0, -1, 1);
        drive_bits(1, 1'b1, 2);
        check("t6_level_full", 32'(lvl(1)), 32'(4));
        check("t6_overrun_set", 32'(ovr_l[1]), 32'(1));
        check_state(1, "t6");
        drain(1, "t6");
        check("t6_overrun_sticky", 32'(ovr_l[1]), 32'(1));
        pulse_clr(1);
        check("t6_overrun_clr", 32'(ovr_l[1]), 32'(0));

        // 7O2: three back-to-back frames
        send_char(2, 9'($urandom_range(0, 127)), 1'b0, -1, 0);
        send_char(2, 9'($urandom_range(0, 127)), 1'b0, -1, 0);
        send_char(2, 9'($urandom_range(0, 127)), 1'b0, -1, 2);
        check("t7_level_three", 32'(lvl(2)), 32'(3));
        check_state(2, "t7");
        drain(2, "t7");

        // Randomised rounds with parity/framing faults, gaps and overflow
        for (int r = 0; r < 9; r++) begin
            int ch, n;
            ch = r % 3;
            n  = $urandom_range(2, cfg_depth[ch] + 2);
            for (int k = 0; k < n; k++) begin
                bit bad_par;
                int bad_stop, gap;
                bad_par  = (cfg_par[ch] != 0) && ($urandom_range(0, 3) == 0);
                bad_stop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cfg_sb[ch] - 1)) : -1;
                gap      = $urandom_range(0, 2);
                if (bad_stop == cfg_sb[ch] - 1 && gap == 0) gap = 1;
                send_char(ch, 9'($urandom_range(0, 511)), bad_par, bad_stop, gap);
            end
            drive_bits(ch, 1'b1, 2);
            check_state(ch, $sformatf("rnd%0d", r));
            drain(ch, $sformatf("rnd%0d", r));
            pulse_clr(ch);
            check($sformatf("rnd%0d_clr", r), 32'(ovr_l[ch]), 32'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
